// File: rtl/axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi4_wr_arbiter
// Round-robin arbiter sharing one AXI4 write path (AW->W->B) among requesters.
// Rev    : 1.0  initial release
// ============================================================================
module axi4_wr_arbiter #(
  parameter int MASTERS_AMOUNT = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int ID_WIDTH       = 1,
  parameter int AWUSER_WIDTH   = 1,
  parameter int WUSER_WIDTH    = 1,
  parameter int BUSER_WIDTH    = 1
) (
  input  logic                                          aclk,
  input  logic                                          areset,
  // requester side
  input  logic [MASTERS_AMOUNT-1:0]                     s_awvalid,
  output logic [MASTERS_AMOUNT-1:0]                     s_awready,
  input  logic [MASTERS_AMOUNT-1:0][ID_WIDTH-1:0]       s_awid,
  input  logic [MASTERS_AMOUNT-1:0][ADDR_WIDTH-1:0]     s_awaddr,
  input  logic [MASTERS_AMOUNT-1:0][7:0]                s_awlen,
  input  logic [MASTERS_AMOUNT-1:0][2:0]                s_awsize,
  input  logic [MASTERS_AMOUNT-1:0][1:0]                s_awburst,
  input  logic [MASTERS_AMOUNT-1:0]                     s_awlock,
  input  logic [MASTERS_AMOUNT-1:0][3:0]                s_awcache,
  input  logic [MASTERS_AMOUNT-1:0][2:0]                s_awprot,
  input  logic [MASTERS_AMOUNT-1:0][3:0]                s_awqos,
  input  logic [MASTERS_AMOUNT-1:0][AWUSER_WIDTH-1:0]   s_awuser,
  input  logic [MASTERS_AMOUNT-1:0]                     s_wvalid,
  output logic [MASTERS_AMOUNT-1:0]                     s_wready,
  input  logic [MASTERS_AMOUNT-1:0][DATA_WIDTH-1:0]     s_wdata,
  input  logic [MASTERS_AMOUNT-1:0][DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic [MASTERS_AMOUNT-1:0]                     s_wlast,
  input  logic [MASTERS_AMOUNT-1:0][WUSER_WIDTH-1:0]    s_wuser,
  output logic [MASTERS_AMOUNT-1:0]                     s_bvalid,
  input  logic [MASTERS_AMOUNT-1:0]                     s_bready,
  output logic [MASTERS_AMOUNT-1:0][ID_WIDTH-1:0]       s_bid,
  output logic [MASTERS_AMOUNT-1:0][1:0]                s_bresp,
  output logic [MASTERS_AMOUNT-1:0][BUSER_WIDTH-1:0]    s_buser,
  input  logic [MASTERS_AMOUNT-1:0]                     s_arvalid,
  output logic [MASTERS_AMOUNT-1:0]                     s_arready,
  input  logic [MASTERS_AMOUNT-1:0][ID_WIDTH-1:0]       s_arid,
  input  logic [MASTERS_AMOUNT-1:0][ADDR_WIDTH-1:0]     s_araddr,
  input  logic [MASTERS_AMOUNT-1:0][7:0]                s_arlen,
  output logic [MASTERS_AMOUNT-1:0]                     s_rvalid,
  input  logic [MASTERS_AMOUNT-1:0]                     s_rready,
  output logic [MASTERS_AMOUNT-1:0][ID_WIDTH-1:0]       s_rid,
  output logic [MASTERS_AMOUNT-1:0][DATA_WIDTH-1:0]     s_rdata,
  output logic [MASTERS_AMOUNT-1:0][1:0]                s_rresp,
  output logic [MASTERS_AMOUNT-1:0]                     s_rlast,
  // shared downstream side
  output logic                                          m_awvalid,
  input  logic                                          m_awready,
  output logic [ID_WIDTH-1:0]                           m_awid,
  output logic [ADDR_WIDTH-1:0]                         m_awaddr,
  output logic [7:0]                                    m_awlen,
  output logic [2:0]                                    m_awsize,
  output logic [1:0]                                    m_awburst,
  output logic                                          m_awlock,
  output logic [3:0]                                    m_awcache,
  output logic [2:0]                                    m_awprot,
  output logic [3:0]                                    m_awqos,
  output logic [AWUSER_WIDTH-1:0]                       m_awuser,
  output logic                                          m_wvalid,
  input  logic                                          m_wready,
  output logic [DATA_WIDTH-1:0]                         m_wdata,
  output logic [DATA_WIDTH/8-1:0]                       m_wstrb,
  output logic                                          m_wlast,
  output logic [WUSER_WIDTH-1:0]                        m_wuser,
  input  logic                                          m_bvalid,
  output logic                                          m_bready,
  input  logic [ID_WIDTH-1:0]                           m_bid,
  input  logic [1:0]                                    m_bresp,
  input  logic [BUSER_WIDTH-1:0]                        m_buser,
  output logic                                          m_arvalid,
  input  logic                                          m_arready,
  output logic [ID_WIDTH-1:0]                           m_arid,
  output logic [ADDR_WIDTH-1:0]                         m_araddr,
  output logic [7:0]                                    m_arlen,
  input  logic                                          m_rvalid,
  output logic                                          m_rready,
  input  logic [ID_WIDTH-1:0]                           m_rid,
  input  logic [DATA_WIDTH-1:0]                         m_rdata,
  input  logic [1:0]                                    m_rresp,
  input  logic                                          m_rlast
);

  localparam int GRANT_W = (MASTERS_AMOUNT > 1) ? $clog2(MASTERS_AMOUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [GRANT_W-1:0] r_grant_idx;
  logic [GRANT_W-1:0] r_last_grant;
  logic [GRANT_W-1:0] w_winner;
  logic               w_found;
  logic               w_b_done;
  logic               w_unused;

  // Round-robin search: slots above last_grant first, then wrap to slot 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < MASTERS_AMOUNT; i++) begin
      if (!w_found && s_awvalid[i] && (GRANT_W'(i) > r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = GRANT_W'(i);
      end
    end
    for (int i = 0; i < MASTERS_AMOUNT; i++) begin
      if (!w_found && s_awvalid[i] && (GRANT_W'(i) <= r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = GRANT_W'(i);
      end
    end
  end

  assign w_b_done = (r_state == S_RESP) && m_bvalid && m_bready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found)                        w_state_next = S_ADDR;
      S_ADDR:  if (m_awvalid && m_awready)         w_state_next = S_DATA;
      S_DATA:  if (m_wvalid && m_wready && m_wlast) w_state_next = S_RESP;
      S_RESP:  if (w_b_done)                       w_state_next = S_IDLE;
      default:                                     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_grant_idx  <= '0;
      r_last_grant <= GRANT_W'(MASTERS_AMOUNT - 1);
    end else begin
      if ((r_state == S_IDLE) && w_found) r_grant_idx <= w_winner;
      if (w_b_done)                      r_last_grant <= r_grant_idx;
    end
  end

  // Downstream payload is zero outside the phase that owns it.
  always_comb begin
    m_awvalid = 1'b0;
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    m_awlock  = 1'b0;
    m_awcache = '0;
    m_awprot  = '0;
    m_awqos   = '0;
    m_awuser  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_wuser   = '0;
    m_bready  = 1'b0;
    case (r_state)
      S_ADDR: begin
        m_awvalid = s_awvalid[r_grant_idx];
        m_awid    = s_awid[r_grant_idx];
        m_awaddr  = s_awaddr[r_grant_idx];
        m_awlen   = s_awlen[r_grant_idx];
        m_awsize  = s_awsize[r_grant_idx];
        m_awburst = s_awburst[r_grant_idx];
        m_awlock  = s_awlock[r_grant_idx];
        m_awcache = s_awcache[r_grant_idx];
        m_awprot  = s_awprot[r_grant_idx];
        m_awqos   = s_awqos[r_grant_idx];
        m_awuser  = s_awuser[r_grant_idx];
      end
      S_DATA: begin
        m_wvalid = s_wvalid[r_grant_idx];
        m_wdata  = s_wdata[r_grant_idx];
        m_wstrb  = s_wstrb[r_grant_idx];
        m_wlast  = s_wlast[r_grant_idx];
        m_wuser  = s_wuser[r_grant_idx];
      end
      S_RESP:  m_bready = s_bready[r_grant_idx];
      default: ;
    endcase
  end

  generate
    for (genvar i = 0; i < MASTERS_AMOUNT; i++) begin : g_slot
      logic w_sel;
      logic w_b_route;
      assign w_sel        = (r_grant_idx == GRANT_W'(i));
      assign w_b_route    = w_sel && (r_state == S_RESP);
      assign s_awready[i] = w_sel && (r_state == S_ADDR) && m_awready;
      assign s_wready[i]  = w_sel && (r_state == S_DATA) && m_wready;
      assign s_bvalid[i]  = w_b_route && m_bvalid;
      assign s_bid[i]     = w_b_route ? m_bid   : '0;
      assign s_bresp[i]   = w_b_route ? m_bresp : '0;
      assign s_buser[i]   = w_b_route ? m_buser : '0;
    end
  endgenerate

  // Read channels are not arbitrated.
  assign s_arready = '0;
  assign s_rvalid  = '0;
  assign s_rid     = '0;
  assign s_rdata   = '0;
  assign s_rresp   = '0;
  assign s_rlast   = '0;
  assign m_arvalid = 1'b0;
  assign m_arid    = '0;
  assign m_araddr  = '0;
  assign m_arlen   = '0;
  assign m_rready  = 1'b0;

  assign w_unused = ^{s_arvalid, s_arid, s_araddr, s_arlen, s_rready,
                      m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast};

endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi4_wr_arbiter
// Directed self-checking bench for axi4_wr_arbiter with three requesters.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi4_wr_arbiter;
  localparam int M = 3;

  logic aclk, areset;
  logic [M-1:0]        s_awvalid, s_awready, s_awlock;
  logic [M-1:0][0:0]   s_awid, s_awuser, s_wuser, s_bid, s_buser, s_arid, s_rid;
  logic [M-1:0][15:0]  s_awaddr, s_araddr;
  logic [M-1:0][7:0]   s_awlen, s_arlen;
  logic [M-1:0][2:0]   s_awsize, s_awprot;
  logic [M-1:0][1:0]   s_awburst, s_bresp, s_rresp;
  logic [M-1:0][3:0]   s_awcache, s_awqos, s_wstrb;
  logic [M-1:0]        s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [M-1:0][31:0]  s_wdata, s_rdata;
  logic [M-1:0]        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic        m_awvalid, m_awready, m_awlock, m_wvalid, m_wready, m_wlast;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [0:0]  m_awid, m_awuser, m_wuser, m_bid, m_buser, m_arid, m_rid;
  logic [15:0] m_awaddr, m_araddr;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_awprot;
  logic [1:0]  m_awburst, m_bresp, m_rresp;
  logic [3:0]  m_awcache, m_awqos, m_wstrb;
  logic [31:0] m_wdata, m_rdata;

  int n_checks, n_pass;

  axi4_wr_arbiter #(.MASTERS_AMOUNT(M), .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(1),
                    .AWUSER_WIDTH(1), .WUSER_WIDTH(1), .BUSER_WIDTH(1)) dut (
    .aclk(aclk), .areset(areset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock),
    .s_awcache(s_awcache), .s_awprot(s_awprot), .s_awqos(s_awqos), .s_awuser(s_awuser),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_wuser(s_wuser),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp), .s_buser(s_buser),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos), .m_awuser(m_awuser),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wuser(m_wuser),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s_awvalid = '0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_awburst = '0; s_awlock = '0; s_awcache = '0; s_awprot = '0; s_awqos = '0;
    s_awuser = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
    s_wuser = '0; s_bready = '0; s_arvalid = '0; s_arid = '0; s_araddr = '0;
    s_arlen = '0; s_rready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    m_buser = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0;
    m_rresp = '0; m_rlast = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_awvalid = 3'b111; s_awaddr[0] = 16'h1234; s_wvalid = 3'b111; s_wdata[0] = 32'hDEAD;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; s_bready = 3'b111;
    step();
    n_checks++; if (m_awvalid !== 1'b0) $display("FAIL rst_m_awvalid got=%0h exp=0", m_awvalid); else n_pass++;
    n_checks++; if (m_wvalid !== 1'b0) $display("FAIL rst_m_wvalid got=%0h exp=0", m_wvalid); else n_pass++;
    n_checks++; if (m_bready !== 1'b0) $display("FAIL rst_m_bready got=%0h exp=0", m_bready); else n_pass++;
    n_checks++; if (s_awready !== 3'b000) $display("FAIL rst_s_awready got=%0h exp=0", s_awready); else n_pass++;
    n_checks++; if (s_wready !== 3'b000) $display("FAIL rst_s_wready got=%0h exp=0", s_wready); else n_pass++;
    n_checks++; if (s_bvalid !== 3'b000) $display("FAIL rst_s_bvalid got=%0h exp=0", s_bvalid); else n_pass++;
    n_checks++; if (m_awaddr !== 16'h0) $display("FAIL rst_m_awaddr got=%0h exp=0", m_awaddr); else n_pass++;
    n_checks++; if (m_wdata !== 32'h0) $display("FAIL rst_m_wdata got=%0h exp=0", m_wdata); else n_pass++;
    n_checks++; if (m_arvalid !== 1'b0 || m_rready !== 1'b0) $display("FAIL rst_m_read got=%0h exp=0", {m_arvalid, m_rready}); else n_pass++;
    n_checks++; if (s_arready !== 3'b0 || s_rvalid !== 3'b0) $display("FAIL rst_s_read got=%0h exp=0", {s_arready, s_rvalid}); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_burst();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    m_awready = 1'b1; m_wready = 1'b1; s_bready = 3'b111;
    s_awvalid[0] = 1'b1; s_awaddr[0] = 16'h0100; s_awlen[0] = 8'd3; s_awsize[0] = 3'd2; s_awburst[0] = 2'd1;
    #1;
    n_checks++; if (m_awvalid !== 1'b0) $display("FAIL single_idle_awvalid got=%0h exp=0", m_awvalid); else n_pass++;
    step();
    s_wvalid[0] = 1'b1; s_wdata[0] = exp_d[0]; s_wstrb[0] = 4'hF;
    #1;
    n_checks++; if (m_awvalid !== 1'b1) $display("FAIL single_awvalid got=%0h exp=1", m_awvalid); else n_pass++;
    n_checks++; if (m_awaddr !== 16'h0100) $display("FAIL single_awaddr got=%0h exp=100", m_awaddr); else n_pass++;
    n_checks++; if (m_awlen !== 8'd3) $display("FAIL single_awlen got=%0h exp=3", m_awlen); else n_pass++;
    n_checks++; if (s_awready !== 3'b001) $display("FAIL single_s_awready got=%0h exp=1", s_awready); else n_pass++;
    n_checks++; if (s_wready !== 3'b000 || m_wvalid !== 1'b0) $display("FAIL single_no_w_in_addr got=%0h exp=0", {s_wready, m_wvalid}); else n_pass++;
    step();
    s_awvalid[0] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_wdata[0] = exp_d[b]; s_wlast[0] = (b == 3);
      #1;
      n_checks++; if (m_wvalid !== 1'b1 || m_wdata !== exp_d[b]) $display("FAIL single_wdata%0d got=%0h exp=%0h", b, m_wdata, exp_d[b]); else n_pass++;
      n_checks++; if (m_wlast !== (b == 3)) $display("FAIL single_wlast%0d got=%0h exp=%0h", b, m_wlast, (b == 3)); else n_pass++;
      n_checks++; if (s_wready !== 3'b001) $display("FAIL single_s_wready%0d got=%0h exp=1", b, s_wready); else n_pass++;
      step();
    end
    s_wvalid[0] = 1'b0; s_wlast[0] = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b00; m_bid = 1'b1;
    #1;
    n_checks++; if (s_bvalid !== 3'b001) $display("FAIL single_s_bvalid got=%0h exp=1", s_bvalid); else n_pass++;
    n_checks++; if (s_bid[0] !== 1'b1 || s_bresp[0] !== 2'b00) $display("FAIL single_b0 got=%0h exp=4", {s_bid[0], s_bresp[0]}); else n_pass++;
    n_checks++; if (s_bid[1] !== 1'b0 || s_bid[2] !== 1'b0) $display("FAIL single_b_other got=%0h exp=0", {s_bid[1], s_bid[2]}); else n_pass++;
    n_checks++; if (m_bready !== 1'b1) $display("FAIL single_m_bready got=%0h exp=1", m_bready); else n_pass++;
    step();
    m_bvalid = 1'b0;
    #1;
    n_checks++; if (s_bvalid !== 3'b000 || m_awvalid !== 1'b0) $display("FAIL single_back_idle got=%0h exp=0", {s_bvalid, m_awvalid}); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; s_bready = 3'b111;
    s_awvalid = 3'b011; s_awaddr[0] = 16'h0A00; s_awaddr[1] = 16'h0B00;
    s_wvalid = 3'b011; s_wlast = 3'b011; s_wdata[0] = 32'hA; s_wdata[1] = 32'hB;
    step();
    n_checks++; if (s_awready !== 3'b001) $display("FAIL simul_first_grant got=%0h exp=1", s_awready); else n_pass++;
    n_checks++; if (m_awaddr !== 16'h0A00) $display("FAIL simul_first_addr got=%0h exp=a00", m_awaddr); else n_pass++;
    step();
    s_awvalid[0] = 1'b0;
    #1;
    n_checks++; if (s_awready !== 3'b000) $display("FAIL simul_data_awready got=%0h exp=0", s_awready); else n_pass++;
    n_checks++; if (s_wready !== 3'b001 || m_wdata !== 32'hA) $display("FAIL simul_data got=%0h exp=a", m_wdata); else n_pass++;
    step();
    s_wvalid[0] = 1'b0; m_bvalid = 1'b1;
    #1;
    n_checks++; if (s_bvalid !== 3'b001 || s_awready !== 3'b000) $display("FAIL simul_resp got=%0h exp=8", {s_bvalid, s_awready}); else n_pass++;
    step();
    m_bvalid = 1'b0;
    #1;
    n_checks++; if (s_awready !== 3'b000 || m_awvalid !== 1'b0) $display("FAIL simul_bubble got=%0h exp=0", {s_awready, m_awvalid}); else n_pass++;
    step();
    n_checks++; if (s_awready !== 3'b010) $display("FAIL simul_second_grant got=%0h exp=2", s_awready); else n_pass++;
    n_checks++; if (m_awaddr !== 16'h0B00) $display("FAIL simul_second_addr got=%0h exp=b00", m_awaddr); else n_pass++;
    step();
    s_awvalid[1] = 1'b0;
    #1;
    n_checks++; if (m_wdata !== 32'hB || s_wready !== 3'b010) $display("FAIL simul_second_data got=%0h exp=b", m_wdata); else n_pass++;
    step();
    s_wvalid = '0; m_bvalid = 1'b1;
    step();
    m_bvalid = 1'b0;
  endtask

  task automatic test_round_robin();
    int ng;
    logic [2:0] exp_oh;
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; s_bready = 3'b111;
    s_awvalid = 3'b111; s_wvalid = 3'b111; s_wlast = 3'b111;
    s_awaddr[0] = 16'h1000; s_awaddr[1] = 16'h2000; s_awaddr[2] = 16'h3000;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
      if (s_awready !== 3'b000) begin
        exp_oh = 3'b001 << (ng % 3);
        n_checks++; if (s_awready !== exp_oh) $display("FAIL rr_grant%0d got=%0h exp=%0h", ng, s_awready, exp_oh); else n_pass++;
        n_checks++; if (m_awaddr !== 16'((ng % 3 + 1) << 12)) $display("FAIL rr_addr%0d got=%0h exp=%0h", ng, m_awaddr, (ng % 3 + 1) << 12); else n_pass++;
        ng++;
      end
      step();
    end
    n_checks++; if (ng != 6) $display("FAIL rr_timeout got=%0d exp=6", ng); else n_pass++;
    do_reset();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    logic [31:0] recv [4];
    int beat, got;
    logic acc;
    exp_d[0] = 32'hA5A50001; exp_d[1] = 32'h5A5A0002; exp_d[2] = 32'hFFFF0003; exp_d[3] = 32'h00000004;
    beat = 0; got = 0;
    s_awvalid[0] = 1'b1; s_awaddr[0] = 16'h4000; s_awlen[0] = 8'd3; s_bready[0] = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (m_awvalid !== 1'b1 || s_awready[0] !== 1'b0) $display("FAIL bp_aw_stall%0d got=%0h exp=2", c, {m_awvalid, s_awready[0]}); else n_pass++;
      step();
    end
    m_awready = 1'b1;
    #1;
    n_checks++; if (s_awready[0] !== 1'b1) $display("FAIL bp_aw_accept got=%0h exp=1", s_awready[0]); else n_pass++;
    step();
    s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b1;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      s_wdata[0] = exp_d[beat]; s_wlast[0] = (beat == 3); m_wready = (c % 2 == 0);
      #1;
      n_checks++; if (s_wready[0] !== m_wready) $display("FAIL bp_wready_c%0d got=%0h exp=%0h", c, s_wready[0], m_wready); else n_pass++;
      if (m_wvalid && m_wready && got < 4) begin recv[got] = m_wdata; got++; end
      acc = s_wready[0];
      step();
      if (acc) beat++;
    end
    s_wvalid[0] = 1'b0; s_wlast[0] = 1'b0; m_wready = 1'b1;
    n_checks++; if (got != 4) $display("FAIL bp_beat_count got=%0d exp=4", got); else n_pass++;
    for (int k = 0; k < 4 && k < got; k++) begin
      n_checks++; if (recv[k] !== exp_d[k]) $display("FAIL bp_data%0d got=%0h exp=%0h", k, recv[k], exp_d[k]); else n_pass++;
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++; if (s_bvalid[0] !== 1'b0 || m_bready !== 1'b1) $display("FAIL bp_b_wait%0d got=%0h exp=1", c, {s_bvalid[0], m_bready}); else n_pass++;
      step();
    end
    m_bvalid = 1'b1; m_bresp = 2'b10;
    #1;
    n_checks++; if (s_bvalid[0] !== 1'b1 || s_bresp[0] !== 2'b10) $display("FAIL bp_bresp got=%0h exp=6", {s_bvalid[0], s_bresp[0]}); else n_pass++;
    step();
    m_bvalid = 1'b0; m_bresp = 2'b00;
  endtask

  task automatic test_reset_mid_burst();
    m_awready = 1'b1; m_wready = 1'b1;
    s_awvalid[1] = 1'b1; s_awaddr[1] = 16'h5000; s_awlen[1] = 8'd3;
    step();
    step();
    s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b1; s_wdata[1] = 32'h51;
    step();
    s_wdata[1] = 32'h52;
    step();
    s_wdata[1] = 32'h53;
    #1;
    n_checks++; if (s_wready[1] !== 1'b1) $display("FAIL mid_pre_reset_wready got=%0h exp=1", s_wready[1]); else n_pass++;
    areset = 1'b1;
    #1;
    n_checks++; if (m_wvalid !== 1'b0 || m_awvalid !== 1'b0 || m_bready !== 1'b0) $display("FAIL mid_async_m got=%0h exp=0", {m_wvalid, m_awvalid, m_bready}); else n_pass++;
    n_checks++; if (s_wready !== 3'b0 || s_awready !== 3'b0 || s_bvalid !== 3'b0) $display("FAIL mid_async_s got=%0h exp=0", {s_wready, s_awready, s_bvalid}); else n_pass++;
    clear_inputs();
    step();
    areset = 1'b0;
    m_awready = 1'b1;
    s_awvalid = 3'b011; s_awaddr[0] = 16'h0C00; s_awaddr[1] = 16'h0D00;
    step();
    n_checks++; if (s_awready !== 3'b001 || m_awaddr !== 16'h0C00) $display("FAIL mid_first_grant got=%0h exp=1", s_awready); else n_pass++;
    do_reset();
  endtask

  task automatic test_early_w();
    m_awready = 1'b1; m_wready = 1'b1; s_bready = 3'b111; m_bvalid = 1'b1;
    s_wvalid[1] = 1'b1; s_wdata[1] = 32'h66; s_wlast[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (s_wready[1] !== 1'b0 || m_wvalid !== 1'b0) $display("FAIL early_w_stall%0d got=%0h exp=0", c, {s_wready[1], m_wvalid}); else n_pass++;
      n_checks++; if (s_bvalid !== 3'b0 || m_bready !== 1'b0) $display("FAIL early_b_ignored%0d got=%0h exp=0", c, {s_bvalid, m_bready}); else n_pass++;
      step();
    end
    m_bvalid = 1'b0;
    s_awvalid[1] = 1'b1; s_awaddr[1] = 16'h6000;
    #1;
    n_checks++; if (s_wready[1] !== 1'b0) $display("FAIL early_idle_wready got=%0h exp=0", s_wready[1]); else n_pass++;
    step();
    n_checks++; if (s_awready[1] !== 1'b1 || s_wready[1] !== 1'b0) $display("FAIL early_addr got=%0h exp=2", {s_awready[1], s_wready[1]}); else n_pass++;
    step();
    s_awvalid[1] = 1'b0;
    #1;
    n_checks++; if (s_wready[1] !== 1'b1 || m_wvalid !== 1'b1 || m_wdata !== 32'h66) $display("FAIL early_first_beat got=%0h exp=66", m_wdata); else n_pass++;
    step();
    s_wvalid[1] = 1'b0; m_bvalid = 1'b1;
    #1;
    n_checks++; if (s_bvalid !== 3'b010) $display("FAIL early_bvalid got=%0h exp=2", s_bvalid); else n_pass++;
    step();
    m_bvalid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    areset   = 1'b1;
    clear_inputs();
    step();
    test_reset();
    test_single_burst();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_reset_mid_burst();
    test_early_w();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
